// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered ALU-control decoder with valid/ready output
// register and a stall sequencer for multi-cycle R-type operations.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready never looks at in_valid, and out_valid, once raised,
// stays high with a stable payload until out_ready is seen.
module alu_ctrl_pipe #(
    parameter int          FUNCT_W   = 4,
    parameter int          CNT_W     = 4,
    parameter int          MC_CYCLES = 4,
    parameter logic [15:0] MC_MASK   = 16'hC000,
    parameter int          STAT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sel,
    input  logic [1:0]         in_opcode,
    input  logic [FUNCT_W-1:0] in_funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   out_alu_cnt,
    output logic               out_mc,
    output logic               busy,
    output logic               mc_done,
    output logic [STAT_W-1:0]  issue_count,
    output logic               dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_cyc;
    logic [7:0]          w_cyc_nxt;
    logic                r_out_valid;
    logic                r_out_mc;
    logic [CNT_W-1:0]    r_out_alu_cnt;
    logic [STAT_W-1:0]   r_issue_count;

    logic [CNT_W-1:0]    w_dec_cnt;
    logic                w_dec_mc;
    logic                w_funct_hi_zero;
    logic                w_accept;
    logic                w_in_ready;

    // Only funct values below 16 can be flagged multi-cycle; wider funct
    // fields need their upper bits checked for zero.
    generate
        if (FUNCT_W > 4) begin : g_funct_wide
            assign w_funct_hi_zero = ~|in_funct[FUNCT_W-1:4];
        end else begin : g_funct_narrow
            assign w_funct_hi_zero = 1'b1;
        end
    endgenerate

    // Decode {sel, opcode, funct} into the control word and multi-cycle flag.
    always_comb begin
        w_dec_cnt = '0;
        w_dec_mc  = 1'b0;
        if (in_sel) begin
            case (in_opcode)
                2'b00:   w_dec_cnt = CNT_W'(4'b0110);
                2'b01:   w_dec_cnt = CNT_W'(4'b1010);
                2'b10:   w_dec_cnt = CNT_W'(4'b0000);
                default: w_dec_cnt = CNT_W'(4'b0001);
            endcase
        end else begin
            case (in_opcode)
                2'b00:   w_dec_cnt = CNT_W'(4'b0110);
                2'b01:   w_dec_cnt = CNT_W'(4'b1000);
                2'b10:   w_dec_cnt = CNT_W'(4'b1001);
                default: begin
                    w_dec_cnt = CNT_W'(in_funct);
                    w_dec_mc  = w_funct_hi_zero & MC_MASK[in_funct[3:0]];
                end
            endcase
        end
    end

    assign w_in_ready = (r_state == ST_IDLE) & (~r_out_valid | out_ready) & ~flush;
    assign w_accept   = in_valid & w_in_ready;

    // Sequencer state and remaining-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
        end
    end

    // Next-state logic: flush returns to IDLE; BUSY counts down to zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_cyc_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_dec_mc) begin
                        w_state_nxt = ST_BUSY;
                        w_cyc_nxt   = 8'(MC_CYCLES - 1);
                    end
                end
                default: begin
                    if (r_cyc == 8'd0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cyc_nxt = r_cyc - 8'd1;
                    end
                end
            endcase
        end
    end

    // Output register: load on accept, drop on consume, clear on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_mc      <= 1'b0;
            r_out_alu_cnt <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_out_mc    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_mc      <= w_dec_mc;
            r_out_alu_cnt <= w_dec_cnt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Count accepted operations; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_count <= '0;
        end else if (w_accept) begin
            r_issue_count <= r_issue_count + STAT_W'(1);
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_mc      = r_out_mc;
    assign out_alu_cnt = r_out_alu_cnt;
    assign issue_count = r_issue_count;
    assign busy        = (r_state == ST_BUSY);
    // A flush in the final busy cycle suppresses the completion pulse.
    assign mc_done     = (r_state == ST_BUSY) & (r_cyc == 8'd0) & ~flush;
    assign dbg_state   = (r_state == ST_BUSY);

endmodule
